// File: rtl/rgb_pkg.sv
// Shared word-format constants and types for the RGB pixel FIFO path.
// Producers and consumers of FIFO words both build and decode them from here.
package rgb_pkg;

    localparam int WORD_W   = 32;
    localparam int PIX_BITS = 24;

    localparam int bnum_valid        = 31;
    localparam int bnum_stream_reset = 30;

    localparam int g_first = 23;
    localparam int g_last  = 16;
    localparam int r_first = 15;
    localparam int r_last  = 8;
    localparam int b_first = 7;
    localparam int b_last  = 0;

    localparam logic [WORD_W-1:0] PIXEL_HDR  = WORD_W'(1) << bnum_valid;
    localparam logic [WORD_W-1:0] RESET_WORD = (WORD_W'(1) << bnum_valid)
                                             | (WORD_W'(1) << bnum_stream_reset);

    typedef enum logic {
        SYNC,
        RUN
    } fill_state_t;

    function automatic logic [WORD_W-1:0] pixel_word(input logic [PIX_BITS-1:0] grb);
        return PIXEL_HDR | {{(WORD_W-PIX_BITS){1'b0}}, grb};
    endfunction

endpackage

// File: rtl/rgb_pix_shift.sv
// Serial-to-parallel GRB pixel accumulator with bit counter.
// word presents the pixel as it stands once the current sbit is included.
module rgb_pix_shift
    import rgb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic                clear,
    input  logic                sbit,
    output logic [PIX_BITS-1:0] word,
    output logic                last_bit,
    output logic                pending
);

    localparam int CNT_W = $clog2(PIX_BITS);

    // Only 23 bits ever need storing: the 24th arrives in the cycle the word is taken.
    logic [PIX_BITS-2:0] shift_reg;
    logic [CNT_W-1:0]    bit_cnt;

    assign word     = {shift_reg, sbit};
    assign last_bit = (bit_cnt == CNT_W'(PIX_BITS - 1));
    assign pending  = (bit_cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            shift_reg <= word[PIX_BITS-2:0];
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rgb_fifo_fill.sv
// Write-side controller for the RGBW pixel FIFO: packs decoded bits into GRB
// words, inserts stream-reset markers and drops words while the FIFO is full.
module rgb_fifo_fill
    import rgb_pkg::*;
#(
    parameter int PIXELS_MAX = 1023,
    parameter int PCNT_W     = $clog2(PIXELS_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_strobe,
    input  logic              in_stream_reset,
    input  logic              in_sbit_value,
    input  logic              in_wr_fifo_full,
    output logic              out_wr_fifo_en,
    output logic [WORD_W-1:0] out_wr_fifo_data,
    output logic              out_overflow,
    output logic              out_short_pixel,
    output logic [PCNT_W-1:0] out_frame_pixels
);

    fill_state_t       state;
    logic              strobe_d;
    logic              last_was_reset;
    logic [PCNT_W-1:0] pix_cnt;

    logic                evt;
    logic                bit_evt;
    logic                rst_evt;
    logic                running;
    logic                shift_en;
    logic                shift_clear;
    logic [PIX_BITS-1:0] grb;
    logic                last_bit;
    logic                pending;

    logic              want_write;
    logic              wr_is_reset;
    logic [WORD_W-1:0] wr_word;

    // Only the first cycle of a strobe counts, however long it is held.
    assign evt     = in_strobe & ~strobe_d;
    assign bit_evt = evt & ~in_stream_reset;
    assign rst_evt = evt &  in_stream_reset;
    assign running = (state == RUN);

    assign shift_en    = bit_evt & running & ~last_bit;
    assign shift_clear = running & (rst_evt | (bit_evt & last_bit));

    rgb_pix_shift u_pix_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (shift_clear),
        .sbit     (in_sbit_value),
        .word     (grb),
        .last_bit (last_bit),
        .pending  (pending)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        want_write  = 1'b0;
        wr_is_reset = 1'b0;
        wr_word     = pixel_word(grb);
        if (rst_evt && (!running || !last_was_reset)) begin
            want_write  = 1'b1;
            wr_is_reset = 1'b1;
            wr_word     = RESET_WORD;
        end else if (bit_evt && running && last_bit) begin
            want_write = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= SYNC;
            strobe_d         <= 1'b0;
            last_was_reset   <= 1'b0;
            pix_cnt          <= '0;
            out_wr_fifo_en   <= 1'b0;
            out_wr_fifo_data <= '0;
            out_overflow     <= 1'b0;
            out_short_pixel  <= 1'b0;
            out_frame_pixels <= '0;
        end else begin
            strobe_d       <= in_strobe;
            out_wr_fifo_en <= 1'b0;

            // A dropped word leaves last_was_reset alone: it tracks words actually written.
            if (want_write) begin
                if (in_wr_fifo_full) begin
                    out_overflow <= 1'b1;
                end else begin
                    out_wr_fifo_en   <= 1'b1;
                    out_wr_fifo_data <= wr_word;
                    last_was_reset   <= wr_is_reset;
                    if (!wr_is_reset && pix_cnt != PCNT_W'(PIXELS_MAX))
                        pix_cnt <= pix_cnt + PCNT_W'(1);
                end
            end

            if (rst_evt) begin
                state <= RUN;
                if (running) begin
                    if (pending)
                        out_short_pixel <= 1'b1;
                    out_frame_pixels <= pix_cnt;
                    pix_cnt          <= '0;
                end
            end
        end
    end

endmodule

// File: doc/rgb_fifo_fill.md
# rgb_fifo_fill

Write-side controller for the pixel FIFO that feeds the RGBW serial output block. It consumes decoded bit events (strobe / stream_reset / sbit_value) from the serial input decoder and packs 24 bits into one GRB pixel word. It also inserts stream-reset marker words and throttles against FIFO full, so the output serializer always sees well-formed 32-bit words.

## Interface
Parameters:
- PIXELS_MAX, 1023: saturation value of the per-frame pixel counter.
- PCNT_W, $clog2(PIXELS_MAX+1): width of the pixel counter (derived).

Ports:
- clk  in  1  system clock, 96 MHz, same clock as FIFO w_clk.
- rst  in  1  reset; **one clock; reset is asynchronous and active-low.**
- in_strobe  in  1  decoder event strobe; high for two clocks per event.
- in_stream_reset  in  1  event is a ≥50 µs line-idle (stream reset).
- in_sbit_value  in  1  bit value when in_stream_reset=0.
- in_wr_fifo_full  in  1  FIFO write-full flag.
- out_wr_fifo_en  out  1  FIFO write-enable, one-clock pulse.
- out_wr_fifo_data  out  32  FIFO write data.
- out_overflow  out  1  sticky: at least one word dropped because the FIFO was full.
- out_short_pixel  out  1  sticky: a stream reset arrived with a partial pixel pending.
- out_frame_pixels  out  PCNT_W  pixel count of the last completed frame.

## Operation
- Word format:
  - bit31 valid.
  - bit30 stream_reset.
  - bits29:24 = 0.
  - bits23:16 G, bits15:8 R, bits7:0 B, each MSB first.
- Pixel word = {1,0,6'b0,grb}. Reset word = {1,1,30'b0}.
- Event detection: event = in_strobe & ~strobe_d. The second strobe cycle is ignored. in_stream_reset and in_sbit_value are sampled in the event cycle.
- FSM states: SYNC (reset state), RUN.
  - SYNC: bit events ignored. A stream-reset event writes a reset word and moves to RUN.
  - RUN, bit event: shift sbit_value into the 24-bit shifter LSB and increment bit_cnt (0..23). When bit_cnt==23, write the pixel word, set bit_cnt=0, and increment the frame pixel counter, saturating at PIXELS_MAX.
  - RUN, stream-reset event:
    - If bit_cnt≠0, discard the partial pixel and set out_short_pixel.
    - Copy the frame pixel counter to out_frame_pixels, then clear it and bit_cnt.
    - Write a reset word unless the previous word written was also a reset word. Consecutive resets collapse to one.
- FIFO full: in_wr_fifo_full is sampled in the event cycle. If high, no write occurs for that event, out_overflow is set, and the pixel counter is not incremented. The shifter still clears, so alignment is kept.
- Sticky flags clear only on reset.
- Reset values:
  - FSM=SYNC, bit_cnt=0, shifter=0, strobe_d=0, last_was_reset=0.
  - out_wr_fifo_en=0, out_wr_fifo_data=0, out_overflow=0, out_short_pixel=0, out_frame_pixels=0.
- Reset asserted mid-pixel or mid-write: all state clears immediately, including any pending write. Operation resumes in SYNC.

## Timing
- Event at cycle N (strobe_d low, in_strobe high). out_wr_fifo_en and out_wr_fifo_data are registered and valid at N+1 for exactly one cycle. Data holds its value until the next write.
- out_frame_pixels and the sticky flags update at N+1 after the triggering event.
- Event spacing is at least ~90 clocks, so there is no back-to-back write. A new event arriving while a write is pending is still handled: each event produces at most one write on the next cycle.
- Events with in_strobe held high longer than two cycles count once.

## Structure
- Shared package rgb_pkg holds:
  - bit-number constants bnum_valid=31, bnum_stream_reset=30, and the G/R/B first/last bit indices;
  - WORD_W=32, PIX_BITS=24;
  - word-builder constants RESET_WORD and PIXEL_HDR.
- Sub-module rgb_pix_shift: 24-bit shifter plus bit counter, with inputs shift_en/clear and outputs word and last_bit.
- FSM, write control and counters live in rgb_fifo_fill.

## Test plan
- Reset word then bits: stream reset, then bits 0xFF00A5 MSB first → two writes: 0xC0000000, then 0x80FF00A5; out_short_pixel=0.
- Sync: 10 bit events after reset, then stream reset → only 0xC0000000 written; no pixel words.
- Partial pixel: 12 bits then stream reset → no pixel word; reset word written; out_short_pixel=1; out_frame_pixels holds the count of the prior frame.
- Full: hold in_wr_fifo_full=1 during the 24th bit of the second pixel → no write, out_overflow=1, out_frame_pixels=1 after the next stream reset. The following pixel writes correctly.
- Collapse and saturation: two consecutive stream resets → one reset word. With PIXELS_MAX=3, send 5 pixels then a reset → out_frame_pixels=3.
- Async reset mid-pixel: deassert rst after 7 bits → all outputs 0, FSM=SYNC, no write emitted.
